// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states and the
// half-select constants used when picking a word out of the 2*XLEN accumulator.
// Optional multiply/divide support is controlled by the ALU_MULDIV_EN macro.
package alu_pkg;

  // Operation codes
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_MUL   = 4'b1010;
  localparam logic [3:0] ALU_MULHU = 4'b1011;
  localparam logic [3:0] ALU_DIVU  = 4'b1100;
  localparam logic [3:0] ALU_REMU  = 4'b1101;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Which half of the accumulator is returned. The accumulator holds
  // {product_hi, product_lo} for multiply and {remainder, quotient} for divide,
  // so MULHU and REMU both read the upper half.
  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

  // True for the four iterative operations.
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_MULHU) ||
           (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

  // Accumulator half that holds the requested result.
  function automatic logic half_sel(input logic [3:0] op);
    return ((op == ALU_MULHU) || (op == ALU_REMU)) ? SEL_HI : SEL_LO;
  endfunction

endpackage

// File: rtl/alu_base_comb.sv
// Combinational evaluator for the single-cycle ALU operations.
// Anything that is not a base op (reserved codes, and mul/div codes which are
// handled elsewhere) evaluates to zero.
module alu_base_comb
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  localparam int SHAMT_W = $clog2(XLEN);

  logic [SHAMT_W-1:0] shamt;
  assign shamt = b[SHAMT_W-1:0];

  // Pick the base-op result; unknown codes give zero
  always_comb begin
    y = '0;
    case (op)
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_XOR:  y = a ^ b;
      ALU_SLL:  y = a << shamt;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = $unsigned($signed(a) >>> shamt);
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked multi-cycle ALU. Base ops complete with one registered cycle of
// latency; unsigned multiply (shift-add) and divide (restoring) iterate one
// bit per cycle for XLEN+1 total cycles. The result is held until accepted.
// Build option: define ALU_MULDIV_EN to include MUL/MULHU/DIVU/REMU; without
// it those codes behave like the reserved codes and busy stays low.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
  logic [XLEN-1:0] base_y;

  alu_base_comb #(.XLEN(XLEN)) u_base (
    .op (op),
    .a  (a),
    .b  (b),
    .y  (base_y)
  );

`ifdef ALU_MULDIV_EN
  localparam int CNT_W = $clog2(XLEN) + 1;

  // acc_q: {hi, lo} = {product_hi, multiplier/product_lo} or {remainder, quotient}
  // opnd_q: multiplicand for multiply, divisor for divide
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sel_hi_q, sel_hi_d;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] div_next;

  // One shift-add multiply step and one restoring divide step from the current accumulator
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    // The true difference is always below the divisor, so XLEN bits suffice.
    div_diff  = div_shift[XLEN-1:0] - opnd_q;
    if (div_shift >= {1'b0, opnd_q}) begin
      div_next = {div_diff, acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end
`endif

  // Next-state and datapath control for the request/iterate/hold sequence
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
`ifdef ALU_MULDIV_EN
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    cnt_d       = cnt_q;
    sel_hi_d    = sel_hi_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
`ifdef ALU_MULDIV_EN
          if (is_muldiv(op)) begin
            cnt_d    = CNT_W'(XLEN);
            sel_hi_d = half_sel(op);
            busy_d   = 1'b1;
            if ((op == ALU_MUL) || (op == ALU_MULHU)) begin
              acc_d   = {{XLEN{1'b0}}, b};
              opnd_d  = a;
              state_d = ST_MUL;
            end else begin
              acc_d   = {{XLEN{1'b0}}, a};
              opnd_d  = b;
              state_d = ST_DIV;
            end
          end else
`endif
          begin
            result_d    = base_y;
            zero_d      = (base_y == '0);
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end
`ifdef ALU_MULDIV_EN
      ST_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d    = sel_hi_q ? mul_next[2*XLEN-1:XLEN] : mul_next[XLEN-1:0];
          zero_d      = (result_d == '0);
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_DONE;
        end
      end
      ST_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d    = sel_hi_q ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
          zero_d      = (result_d == '0);
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

`ifdef ALU_MULDIV_EN
  // Iteration datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      sel_hi_q <= SEL_LO;
    end else begin
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      sel_hi_q <= sel_hi_d;
    end
  end
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed table, corner-case sequences
// (reset mid-divide, back-pressure, 8-bit instance) and randomized ops checked
// against an arithmetic reference model. Honours ALU_MULDIV_EN.
module tb_alu_seq_unit;

`ifdef ALU_MULDIV_EN
  localparam bit MULDIV_ON = 1'b1;
`else
  localparam bit MULDIV_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [3:0]  op8 = 4'd0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        out_valid8;
  logic [7:0]  result8;
  logic        zero8;
  logic        busy8;

  int n_cmp = 0;
  int n_err = 0;
  bit busy_seen = 1'b0;

  always #5 clk = ~clk;

  alu_seq_unit #(.XLEN(32)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );

  alu_seq_unit #(.XLEN(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(1'b1),
    .result(result8), .zero(zero8), .busy(busy8)
  );

  always @(negedge clk) if (busy === 1'b1) busy_seen = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_md(input logic [3:0] o);
    return (o >= 4'd10) && (o <= 4'd13);
  endfunction

  // Reference: straight arithmetic on the operands
  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    int unsigned sh;
    p  = {32'd0, x} * {32'd0, y};
    sh = y % 32;
    case (o)
      4'd0:  return x & y;
      4'd1:  return x | y;
      4'd2:  return x + y;
      4'd3:  return x ^ y;
      4'd4:  return x << sh;
      4'd5:  return x >> sh;
      4'd6:  return x - y;
      4'd7:  return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
      4'd8:  return (x < y) ? 32'd1 : 32'd0;
      4'd9:  return 32'(int'(x) >>> sh);
      4'd10: return MULDIV_ON ? p[31:0] : 32'd0;
      4'd11: return MULDIV_ON ? p[63:32] : 32'd0;
      4'd12: return MULDIV_ON ? ((y == 0) ? 32'hFFFF_FFFF : x / y) : 32'd0;
      4'd13: return MULDIV_ON ? ((y == 0) ? x : x % y) : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] o);
    return (MULDIV_ON && is_md(o)) ? 33 : 1;
  endfunction

  // One full transaction: request, wait for result, check, accept
  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_r, input int lat_exp, input string tag);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
    check({tag, "_result"}, 64'(result), 64'(exp_r));
    check({tag, "_zero"}, 64'(zero), 64'(exp_r == 0));
    $display("op=%0d a=0x%08h b=0x%08h -> result=0x%08h zero=%0d lat=%0d (%s)",
             o, x, y, result, zero, lat, tag);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tv[14];

  initial begin
    logic [31:0] e;
    logic [3:0]  ro;
    logic [31:0] ra, rb;

    tv[0]  = '{4'b0110, 32'd5,          32'd5,          32'h0000_0000, "sub_eq"};
    tv[1]  = '{4'b0010, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, "add_wrap"};
    tv[2]  = '{4'b1001, 32'h8000_0000,  32'd31,         32'hFFFF_FFFF, "sra31"};
    tv[3]  = '{4'b0100, 32'd1,          32'd33,         32'h0000_0002, "sll_mask"};
    tv[4]  = '{4'b0111, 32'hFFFF_FFFF,  32'd1,          32'h0000_0001, "slt_neg"};
    tv[5]  = '{4'b1000, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, "sltu"};
    tv[6]  = '{4'b0011, 32'hF0F0_1234,  32'h0FF0_1234,  32'hFF00_0000, "xor"};
    tv[7]  = '{4'b1110, 32'h1234_5678,  32'h1,          32'h0000_0000, "reserved"};
    tv[8]  = '{4'b1011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, "mulhu"};
    tv[9]  = '{4'b1010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, "mul"};
    tv[10] = '{4'b1100, 32'd100,        32'd7,          32'd14,        "divu"};
    tv[11] = '{4'b1101, 32'd100,        32'd7,          32'd2,         "remu"};
    tv[12] = '{4'b1100, 32'd9,          32'd0,          32'hFFFF_FFFF, "divu_by0"};
    tv[13] = '{4'b1101, 32'd9,          32'd0,          32'd9,         "remu_by0"};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); reset = 1'b0;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      e = (!MULDIV_ON && is_md(tv[i].op)) ? 32'd0 : tv[i].exp;
      do_op(tv[i].op, tv[i].a, tv[i].b, e, exp_lat(tv[i].op), tv[i].name);
    end

    // Reset in the middle of a divide
    @(negedge clk);
    in_valid = 1'b1; op = 4'b1100; a = 32'd100; b = 32'd7;
    @(posedge clk); #1; in_valid = 1'b0;
    check("middiv_busy", 64'(busy), 64'(MULDIV_ON));
    repeat (9) @(posedge clk);
    #1;
    check("middiv_not_done", 64'(out_valid), 64'(!MULDIV_ON));
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("middiv_rst_ov", 64'(out_valid), 64'd0);
    check("middiv_rst_busy", 64'(busy), 64'd0);
    check("middiv_rst_result", 64'(result), 64'd0);
    check("middiv_rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk); reset = 1'b0;
    do_op(4'b1100, 32'd100, 32'd7, MULDIV_ON ? 32'd14 : 32'd0, exp_lat(4'b1100), "after_rst");

    // Back-pressure: result held, requests ignored
    @(negedge clk);
    in_valid = 1'b1; op = 4'b0010; a = 32'd3; b = 32'd4;
    @(posedge clk); #1; in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("bp_ov", 64'(out_valid), 64'd1);
      check("bp_result", 64'(result), 64'd7);
      check("bp_zero", 64'(zero), 64'd0);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      if (c == 2) begin
        @(negedge clk); in_valid = 1'b1; op = 4'b0110; a = 32'd1; b = 32'd1;
        @(posedge clk); #1; in_valid = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    $display("back-pressure hold: result=0x%08h out_valid=%0d", result, out_valid);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("bp_release_ready", 64'(in_ready), 64'd1);
    check("bp_release_ov", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("bp_pulse_ignored", 64'(out_valid), 64'd0);

    // 8-bit instance
    @(negedge clk); in_valid8 = 1'b1; op8 = 4'b0111; a8 = 8'h80; b8 = 8'h01;
    @(posedge clk); #1; in_valid8 = 1'b0;
    check("x8_slt_ov", 64'(out_valid8), 64'd1);
    check("x8_slt", 64'(result8), 64'd1);
    $display("xlen8 slt 0x80<0x01 -> result=0x%02h", result8);
    @(posedge clk); #1;
    @(negedge clk); in_valid8 = 1'b1; op8 = 4'b1001; a8 = 8'h80; b8 = 8'h07;
    @(posedge clk); #1; in_valid8 = 1'b0;
    check("x8_sra", 64'(result8), 64'hFF);
    check("x8_busy", 64'(busy8), 64'd0);
    $display("xlen8 sra 0x80>>>7 -> result=0x%02h", result8);

    // Random ops against the model
    for (int i = 0; i < 150; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 40));
        default: rb = $urandom;
      endcase
      do_op(ro, ra, rb, model(ro, ra, rb), exp_lat(ro), "rand");
    end

    check("busy_seen", 64'(busy_seen), 64'(MULDIV_ON));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
